// File: rtl/trigger_encoder.sv
// Multi-channel trigger encoder: synchronizes raw trigger lines, detects
// level/edge hits per channel and emits one-cycle trigger strobes with holdoff.
module trigger_encoder #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic                 auto_rearm,
    input  logic [3:0]           trig_in,
    input  logic [3:0]           trig_mask,
    input  logic [3:0]           trig_mode,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 trigger_ready,
    output logic [3:0]           trigger_vector,
    output logic                 armed,
    output logic [HOLDOFF_W-1:0] fire_count
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HOLDOFF
    } state_t;

    state_t               state;
    logic [3:0]           sync [SYNC_STAGES];
    logic [3:0]           s;
    logic [3:0]           p;
    logic [3:0]           h;
    logic                 fire;
    logic [HOLDOFF_W-1:0] hold_lat;
    logic [HOLDOFF_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
            p <= '0;
        end else begin
            sync[0] <= trig_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            p <= s;
        end
    end

    assign s = sync[SYNC_STAGES-1];

    always_comb begin
        h    = trig_mask & ((trig_mode & s & ~p) | (~trig_mode & s));
        fire = (state == ARMED) && (|h) && !disarm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            armed          <= 1'b0;
            trigger_ready  <= 1'b0;
            trigger_vector <= '0;
            fire_count     <= '0;
            hold_lat       <= '0;
            cnt            <= '0;
        end else begin
            trigger_ready  <= 1'b0;
            trigger_vector <= '0;
            if (fire) begin
                trigger_ready  <= 1'b1;
                trigger_vector <= h;
                if (fire_count != '1) fire_count <= fire_count + 1'b1;
            end
            if (disarm) begin
                state <= IDLE;
                armed <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (arm) begin
                            state    <= ARMED;
                            armed    <= 1'b1;
                            hold_lat <= holdoff;
                        end
                    end
                    ARMED: begin
                        if (|h) begin
                            // zero holdoff skips the dead-time state entirely
                            if (hold_lat == '0) begin
                                state <= auto_rearm ? ARMED : IDLE;
                                armed <= auto_rearm;
                            end else begin
                                state <= HOLDOFF;
                                armed <= 1'b0;
                                cnt   <= hold_lat - 1'b1;
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (cnt == '0) begin
                            state <= auto_rearm ? ARMED : IDLE;
                            armed <= auto_rearm;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        armed <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trigger_encoder.sv
// Directed self-checking bench for trigger_encoder.
// Outputs are sampled 1 time unit after each rising edge.
module tb_trigger_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        disarm;
    logic        auto_rearm;
    logic [3:0]  trig_in;
    logic [3:0]  trig_mask;
    logic [3:0]  trig_mode;
    logic [15:0] holdoff;
    logic        trigger_ready;
    logic [3:0]  trigger_vector;
    logic        armed;
    logic [15:0] fire_count;

    int n_checks = 0;
    int n_fail   = 0;

    trigger_encoder dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .disarm         (disarm),
        .auto_rearm     (auto_rearm),
        .trig_in        (trig_in),
        .trig_mask      (trig_mask),
        .trig_mode      (trig_mode),
        .holdoff        (holdoff),
        .trigger_ready  (trigger_ready),
        .trigger_vector (trigger_vector),
        .armed          (armed),
        .fire_count     (fire_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] pat [10];
        int bad;
        pat = '{4'hF, 4'h0, 4'h5, 4'hA, 4'h3, 4'hC, 4'hF, 4'h1, 4'h8, 4'h0};

        rst = 1'b1; arm = 1'b0; disarm = 1'b0; auto_rearm = 1'b0;
        trig_in = '0; trig_mask = '0; trig_mode = '0; holdoff = '0;
        tick();
        tick();
        chk("rst_ready", 32'(trigger_ready), 32'd0);
        chk("rst_vector", 32'(trigger_vector), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_count", 32'(fire_count), 32'd0);

        // no fire before arm
        rst = 1'b0; trig_mask = 4'b0001; trig_in = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("prearm_ready", 32'(trigger_ready), 32'd0);
        end
        chk("prearm_count", 32'(fire_count), 32'd0);
        trig_in = '0;
        repeat (3) tick();

        // level fire, latency SYNC_STAGES
        holdoff = 16'd3; auto_rearm = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("l_armed", 32'(armed), 32'd1);
        trig_in = 4'b0001;
        tick();
        chk("l_k", 32'(trigger_ready), 32'd0);
        tick();
        chk("l_k1", 32'(trigger_ready), 32'd0);
        tick();
        chk("l_ready", 32'(trigger_ready), 32'd1);
        chk("l_vector", 32'(trigger_vector), 32'h1);
        chk("l_count", 32'(fire_count), 32'd1);
        tick();
        trig_in = '0;
        chk("l_ready_off", 32'(trigger_ready), 32'd0);
        chk("l_vector_off", 32'(trigger_vector), 32'd0);
        chk("l_hold_armed", 32'(armed), 32'd0);
        repeat (3) tick();
        chk("l_idle_armed", 32'(armed), 32'd0);
        chk("l_idle_count", 32'(fire_count), 32'd1);

        // edge mode with holdoff=5, second pulse discarded
        trig_mode = 4'hF; trig_mask = 4'hF; holdoff = 16'd5;
        auto_rearm = 1'b1;
        repeat (2) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("e_armed", 32'(armed), 32'd1);
        trig_in = 4'b0100;
        tick();
        trig_in = '0;
        tick();
        tick();
        chk("e_ready", 32'(trigger_ready), 32'd1);
        chk("e_vector", 32'(trigger_vector), 32'h4);
        chk("e_count", 32'(fire_count), 32'd2);
        trig_in = 4'b0100;
        tick();
        trig_in = '0;
        for (int i = 1; i <= 3; i++) begin
            chk("e_hold_armed", 32'(armed), 32'd0);
            chk("e_hold_ready", 32'(trigger_ready), 32'd0);
            tick();
        end
        chk("e_hold_last", 32'(armed), 32'd0);
        tick();
        chk("e_rearm", 32'(armed), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("e_no_refire", 32'(trigger_ready), 32'd0);
        end
        chk("e_count2", 32'(fire_count), 32'd2);

        // simultaneous hits
        trig_in = 4'b1010;
        tick();
        tick();
        tick();
        chk("m_ready", 32'(trigger_ready), 32'd1);
        chk("m_vector", 32'(trigger_vector), 32'hA);
        chk("m_count", 32'(fire_count), 32'd3);
        repeat (5) tick();
        chk("m_rearm", 32'(armed), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("m_edge_no_refire", 32'(trigger_ready), 32'd0);
        end
        trig_in = '0;

        // masking
        trig_mask = 4'h0;
        for (int i = 0; i < 10; i++) begin
            trig_in = pat[i];
            tick();
            chk("mask_ready", 32'(trigger_ready), 32'd0);
        end
        trig_in = '0;
        repeat (3) tick();
        chk("mask_count", 32'(fire_count), 32'd3);

        // disarm in the hit cycle
        trig_mask = 4'hF;
        trig_in = 4'b0001;
        tick();
        tick();
        disarm = 1'b1;
        tick();
        chk("d_ready", 32'(trigger_ready), 32'd0);
        chk("d_count", 32'(fire_count), 32'd3);
        chk("d_armed", 32'(armed), 32'd0);
        disarm = 1'b0;
        tick();
        chk("d_ready2", 32'(trigger_ready), 32'd0);
        trig_in = '0;

        // level re-fire every cycle up to saturation
        trig_mode = 4'h0; trig_mask = 4'b0010; trig_in = 4'b0010;
        holdoff = '0; auto_rearm = 1'b1;
        repeat (3) tick();
        chk("s_idle_ready", 32'(trigger_ready), 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("s_arm_ready", 32'(trigger_ready), 32'd0);
        chk("s_armed", 32'(armed), 32'd1);
        bad = 0;
        for (int i = 1; i <= 65532; i++) begin
            tick();
            if (trigger_ready !== 1'b1 || trigger_vector !== 4'b0010) bad++;
            if (i == 65531) chk("s_count_fffe", 32'(fire_count), 32'hFFFE);
        end
        chk("s_strobe_each_cycle", 32'(bad), 32'd0);
        chk("s_count_ffff", 32'(fire_count), 32'hFFFF);
        tick();
        tick();
        chk("s_count_hold", 32'(fire_count), 32'hFFFF);
        chk("s_ready_still", 32'(trigger_ready), 32'd1);
        chk("s_armed_still", 32'(armed), 32'd1);

        // reset mid-holdoff
        holdoff = 16'd10;
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("r_disarm_ready", 32'(trigger_ready), 32'd0);
        chk("r_disarm_armed", 32'(armed), 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        chk("r_fire", 32'(trigger_ready), 32'd1);
        chk("r_hold_armed", 32'(armed), 32'd0);
        tick();
        chk("r_hold_ready", 32'(trigger_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_ready", 32'(trigger_ready), 32'd0);
        chk("r_vector", 32'(trigger_vector), 32'd0);
        chk("r_armed", 32'(armed), 32'd0);
        chk("r_count", 32'(fire_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r_idle_ready", 32'(trigger_ready), 32'd0);
            chk("r_idle_armed", 32'(armed), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
